itrx_aib_phy_io_tx_seq: RTL and testbench

ITRX_AIB_PHY_IO_TX_SEQ -- requirements
Module: itrx_aib_phy_io_tx_seq

---
 rtl/itrx_aib_phy_pkg.sv | 41 ++++
 rtl/itrx_aib_phy_sync.sv | 25 ++
 rtl/itrx_aib_phy_io_tx_seq.sv | 154 +++++++++++++++
 tb/tb_itrx_aib_phy_io_tx_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itrx_aib_phy_pkg.sv
// Shared types and defaults for the AIB PHY I/O transmit sequencer.
package itrx_aib_phy_pkg;

    // Pad mode encodings as seen on mode_req / mode_cur.
    typedef enum logic [1:0] {
        ModeHiz    = 2'd0,
        ModeWeakPu = 2'd1,
        ModeWeakPd = 2'd2,
        ModeDrive  = 2'd3
    } pad_mode_e;

    typedef enum logic [1:0] {
        StPorHold = 2'd0,
        StStable  = 2'd1,
        StBreak   = 2'd2,
        StMake    = 2'd3
    } tx_seq_state_e;

    localparam int unsigned SettleCycDefault  = 4;
    localparam int unsigned SyncStagesDefault = 2;

    typedef struct packed {
        logic tx_en_buf;
        logic weakp1;
        logic weakp0;
    } pad_ctl_t;

    // At most one of the three pad enables is ever set for a given mode.
    function automatic pad_ctl_t mode_decode(input pad_mode_e mode);
        pad_ctl_t ctl;
        ctl = '0;
        unique case (mode)
            ModeWeakPu: ctl.weakp1    = 1'b1;
            ModeWeakPd: ctl.weakp0    = 1'b1;
            ModeDrive:  ctl.tx_en_buf = 1'b1;
            default:    ctl           = '0;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/itrx_aib_phy_sync.sv
// Multi-flop synchronizer with a selectable synchronous reset value.
module itrx_aib_phy_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through STAGES flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{rst_val}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/itrx_aib_phy_io_tx_seq.sv
// Break-before-make pad mode sequencer for the AIB PHY transmit I/O.
module itrx_aib_phy_io_tx_seq
    import itrx_aib_phy_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = SettleCycDefault,
    parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       por_vcc_io,
    input  logic [1:0] mode_req,
    input  logic [1:0] str_req,
    input  logic       req_vld,
    output logic       req_rdy,
    input  logic       tx_dat,
    output logic       tx_en_buf,
    output logic       txdat_mux,
    output logic       weakp1,
    output logic       weakp0,
    output logic [1:0] ipdrv,
    output logic [1:0] indrv,
    output logic [1:0] mode_cur,
    output logic       done
);

    localparam logic [3:0] CntLoad = 4'(SETTLE_CYC - 1);

    logic          por_s;
    logic          accept;
    logic          same_req;
    tx_seq_state_e state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    pad_mode_e     mode_q, mode_d;
    pad_mode_e     lat_mode_q, lat_mode_d;
    logic [1:0]    str_q, str_d;
    logic          done_q, done_d;
    logic          txdat_q;
    pad_ctl_t      ctl;

    // Reset to 1 so the pad stays in POR_HOLD until the I/O supply is seen good.
    itrx_aib_phy_sync #(
        .STAGES (SYNC_STAGES)
    ) u_por_sync (
        .clk     (clk),
        .rst     (rst),
        .rst_val (1'b1),
        .d       (por_vcc_io),
        .q       (por_s)
    );

    assign req_rdy  = (state_q == StStable) && !por_s;
    assign accept   = req_vld && req_rdy;
    assign same_req = (mode_req == mode_q) && (str_req == str_q);

    // State, counter and latched-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StPorHold;
            cnt_q      <= '0;
            mode_q     <= ModeWeakPd;
            lat_mode_q <= ModeHiz;
            str_q      <= '0;
            done_q     <= 1'b0;
            txdat_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            lat_mode_q <= lat_mode_d;
            str_q      <= str_d;
            done_q     <= done_d;
            txdat_q    <= tx_dat;
        end
    end

    // Next-state: POR overrides everything and drops any in-flight request silently.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        lat_mode_d = lat_mode_q;
        str_d      = str_q;
        done_d     = 1'b0;
        if (por_s) begin
            state_d = StPorHold;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StPorHold: begin
                    state_d    = StStable;
                    mode_d     = ModeWeakPd;
                    lat_mode_d = ModeWeakPd;
                    str_d      = '0;
                end
                StStable: begin
                    if (accept) begin
                        if (same_req) begin
                            done_d = 1'b1;
                        end else begin
                            state_d    = StBreak;
                            lat_mode_d = pad_mode_e'(mode_req);
                            str_d      = str_req;
                            cnt_d      = CntLoad;
                        end
                    end
                end
                StBreak: begin
                    if (cnt_q == '0) begin
                        state_d = StMake;
                        mode_d  = lat_mode_q;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StMake: begin
                    state_d = StStable;
                    done_d  = 1'b1;
                end
                default: state_d = StPorHold;
            endcase
        end
    end

    // Pad output decode from the registered state and applied mode.
    always_comb begin
        ctl       = '0;
        txdat_mux = 1'b0;
        ipdrv     = str_q;
        indrv     = str_q;
        mode_cur  = mode_q;
        unique case (state_q)
            StPorHold: begin
                ctl.weakp0 = 1'b1;
                ipdrv      = '0;
                indrv      = '0;
                mode_cur   = ModeWeakPd;
            end
            StBreak: begin
                mode_cur = ModeHiz;
            end
            StStable, StMake: begin
                ctl       = mode_decode(mode_q);
                txdat_mux = (mode_q == ModeDrive) && txdat_q;
            end
            default: ctl = '0;
        endcase
    end

    assign tx_en_buf = ctl.tx_en_buf;
    assign weakp1    = ctl.weakp1;
    assign weakp0    = ctl.weakp0;
    assign done      = done_q;

endmodule

// File: tb/tb_itrx_aib_phy_io_tx_seq.sv
// Directed and randomized checks for the pad mode sequencer.
module tb_itrx_aib_phy_io_tx_seq;

    localparam int unsigned SyncStages = 2;

    logic       clk;
    logic       rst;
    logic       por_vcc_io;
    logic [1:0] mode_req;
    logic [1:0] str_req;
    logic       req_vld;
    logic       req_rdy;
    logic       tx_dat;
    logic       tx_en_buf;
    logic       txdat_mux;
    logic       weakp1;
    logic       weakp0;
    logic [1:0] ipdrv;
    logic [1:0] indrv;
    logic [1:0] mode_cur;
    logic       done;

    logic [11:0] obs;
    logic [11:0] e;
    int          n_checks;
    int          n_pass;

    itrx_aib_phy_io_tx_seq #(
        .SETTLE_CYC  (4),
        .SYNC_STAGES (SyncStages)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .por_vcc_io (por_vcc_io),
        .mode_req   (mode_req),
        .str_req    (str_req),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .tx_dat     (tx_dat),
        .tx_en_buf  (tx_en_buf),
        .txdat_mux  (txdat_mux),
        .weakp1     (weakp1),
        .weakp0     (weakp0),
        .ipdrv      (ipdrv),
        .indrv      (indrv),
        .mode_cur   (mode_cur),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {req_rdy, done, tx_en_buf, weakp1, weakp0, txdat_mux, ipdrv, indrv, mode_cur};

    function automatic logic [11:0] exp_obs(input logic rdy, input logic dn, input logic en,
                                            input logic p1, input logic p0, input logic tx,
                                            input logic [1:0] ip, input logic [1:0] inn,
                                            input logic [1:0] mc);
        return {rdy, dn, en, p1, p0, tx, ip, inn, mc};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        por_vcc_io = 1'b0;
        repeat (3) tick();
        e = exp_obs(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2);
        n_checks++;
        if (obs !== e) $display("FAIL reset_hold: got %03h want %03h", obs, e); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (obs !== e) $display("FAIL reset_rel1: got %03h want %03h", obs, e); else n_pass++;
        tick();
        n_checks++;
        if (obs !== e) $display("FAIL reset_rel2: got %03h want %03h", obs, e); else n_pass++;
        tick();
        e = exp_obs(1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2);
        n_checks++;
        if (obs !== e) $display("FAIL reset_stable: got %03h want %03h", obs, e); else n_pass++;
    endtask

    task automatic test_change_to_drive;
        mode_req = 2'd3;
        str_req  = 2'd3;
        req_vld  = 1'b1;
        tick();
        req_vld = 1'b0;
        e = exp_obs(0, 0, 0, 0, 0, 0, 2'd3, 2'd3, 2'd0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs !== e) $display("FAIL break_cyc%0d: got %03h want %03h", i, obs, e);
            else n_pass++;
            tick();
        end
        e = exp_obs(0, 0, 1, 0, 0, 0, 2'd3, 2'd3, 2'd3);
        n_checks++;
        if (obs !== e) $display("FAIL make_drive: got %03h want %03h", obs, e); else n_pass++;
        tick();
        e = exp_obs(1, 1, 1, 0, 0, 0, 2'd3, 2'd3, 2'd3);
        n_checks++;
        if (obs !== e) $display("FAIL done_drive: got %03h want %03h", obs, e); else n_pass++;
        tick();
        e = exp_obs(1, 0, 1, 0, 0, 0, 2'd3, 2'd3, 2'd3);
        n_checks++;
        if (obs !== e) $display("FAIL drive_idle: got %03h want %03h", obs, e); else n_pass++;
    endtask

    task automatic test_txdata;
        logic [2:0] pat;
        logic       seen;
        pat = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            tx_dat = pat[i];
            tick();
            n_checks++;
            if (txdat_mux !== pat[i])
                $display("FAIL txdat_bit%0d: got %0b want %0b", i, txdat_mux, pat[i]);
            else n_pass++;
        end
        mode_req = 2'd0;
        str_req  = 2'd3;
        req_vld  = 1'b1;
        tick();
        req_vld = 1'b0;
        e = exp_obs(0, 0, 0, 0, 0, 0, 2'd3, 2'd3, 2'd0);
        n_checks++;
        if (obs !== e) $display("FAIL txdat_break: got %03h want %03h", obs, e); else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = done;
        end
        e = exp_obs(1, 1, 0, 0, 0, 0, 2'd3, 2'd3, 2'd0);
        n_checks++;
        if (obs !== e) $display("FAIL hiz_done: got %03h want %03h", obs, e); else n_pass++;
    endtask

    task automatic test_same_request;
        mode_req = 2'd0;
        str_req  = 2'd3;
        req_vld  = 1'b1;
        tick();
        req_vld = 1'b0;
        e = exp_obs(1, 1, 0, 0, 0, 0, 2'd3, 2'd3, 2'd0);
        n_checks++;
        if (obs !== e) $display("FAIL same_done: got %03h want %03h", obs, e); else n_pass++;
        tick();
        e = exp_obs(1, 0, 0, 0, 0, 0, 2'd3, 2'd3, 2'd0);
        n_checks++;
        if (obs !== e) $display("FAIL same_after: got %03h want %03h", obs, e); else n_pass++;
    endtask

    task automatic test_hiz_strength;
        int n;
        mode_req = 2'd0;
        str_req  = 2'd1;
        req_vld  = 1'b1;
        tick();
        req_vld = 1'b0;
        e = exp_obs(0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0);
        n_checks++;
        if (obs !== e) $display("FAIL hizstr_break: got %03h want %03h", obs, e); else n_pass++;
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 6) $display("FAIL hizstr_latency: got %0d want 6", n); else n_pass++;
        e = exp_obs(1, 1, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0);
        n_checks++;
        if (obs !== e) $display("FAIL hizstr_done: got %03h want %03h", obs, e); else n_pass++;
    endtask

    task automatic test_por_break;
        int   n;
        logic bad;
        mode_req = 2'd1;
        str_req  = 2'd2;
        req_vld  = 1'b1;
        tick();
        req_vld = 1'b0;
        e = exp_obs(0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 2'd0);
        n_checks++;
        if (obs !== e) $display("FAIL por_break: got %03h want %03h", obs, e); else n_pass++;
        tick();
        por_vcc_io = 1'b1;
        tick();
        por_vcc_io = 1'b0;
        n   = 0;
        bad = 1'b0;
        while (!(mode_cur == 2'd2 && !req_rdy) && n < int'(SyncStages) + 1) begin
            tick();
            n++;
            bad = bad | done | weakp1;
        end
        e = exp_obs(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2);
        n_checks++;
        if (obs !== e) $display("FAIL por_hold: got %03h want %03h after %0d", obs, e, n);
        else n_pass++;
        tick();
        e = exp_obs(1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2);
        n_checks++;
        if (obs !== e) $display("FAIL por_recover: got %03h want %03h", obs, e); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            bad = bad | done | weakp1;
        end
        n_checks++;
        if (bad !== 1'b0) $display("FAIL por_no_done: got %0b want 0", bad); else n_pass++;
    endtask

    task automatic test_rst_abort;
        logic bad;
        mode_req = 2'd3;
        str_req  = 2'd1;
        req_vld  = 1'b1;
        tick();
        req_vld = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e = exp_obs(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2);
        n_checks++;
        if (obs !== e) $display("FAIL rst_abort: got %03h want %03h", obs, e); else n_pass++;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            bad = bad | done | tx_en_buf;
        end
        n_checks++;
        if (bad !== 1'b0) $display("FAIL rst_no_done: got %0b want 0", bad); else n_pass++;
        e = exp_obs(1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2);
        n_checks++;
        if (obs !== e) $display("FAIL rst_stable: got %03h want %03h", obs, e); else n_pass++;
    endtask

    task automatic test_random;
        int          accepts;
        int          dones;
        int          cycles;
        int          excl_bad;
        int          drive_bad;
        logic [11:0] prev;
        accepts   = 0;
        dones     = 0;
        cycles    = 0;
        excl_bad  = 0;
        drive_bad = 0;
        prev      = obs;
        while (accepts < 1000 && cycles < 20000) begin
            tx_dat   = 1'($urandom_range(0, 1));
            mode_req = 2'($urandom_range(0, 3));
            str_req  = 2'($urandom_range(0, 3));
            req_vld  = ($urandom_range(0, 3) != 0);
            if (req_vld && req_rdy) accepts++;
            tick();
            cycles++;
            if (done) dones++;
            if (int'(tx_en_buf) + int'(weakp0) + int'(weakp1) > 1) excl_bad++;
            // Entering DRIVE must come straight out of an all-off, not-ready HIZ cycle.
            if (tx_en_buf && !prev[9] && (prev[11] || prev[9:7] != 3'b000 || prev[1:0] != 2'd0))
                drive_bad++;
            prev = obs;
        end
        req_vld = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) dones++;
            if (int'(tx_en_buf) + int'(weakp0) + int'(weakp1) > 1) excl_bad++;
        end
        n_checks++;
        if (accepts !== 1000) $display("FAIL rand_accepts: got %0d want 1000", accepts);
        else n_pass++;
        n_checks++;
        if (excl_bad !== 0) $display("FAIL rand_exclusive: got %0d want 0", excl_bad);
        else n_pass++;
        n_checks++;
        if (drive_bad !== 0) $display("FAIL rand_drive_entry: got %0d want 0", drive_bad);
        else n_pass++;
        n_checks++;
        if (dones !== accepts) $display("FAIL rand_dones: got %0d want %0d", dones, accepts);
        else n_pass++;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        por_vcc_io = 1'b0;
        mode_req   = 2'd0;
        str_req    = 2'd0;
        req_vld    = 1'b0;
        tx_dat     = 1'b0;
        test_reset();
        test_change_to_drive();
        test_txdata();
        test_same_request();
        test_hiz_strength();
        test_por_break();
        test_rst_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
